// File: rtl/axi_slice_rr_arbiter_if.sv
// Requester-side and downstream-side signals of the round-robin slice arbiter.
// master = requesters plus downstream sink; slave = the arbiter itself.
interface axi_slice_rr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 64
);
   localparam int IDX_WIDTH = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid_i;
   logic [NUM_REQ-1:0]            req_ready_o;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
   logic [NUM_REQ-1:0]            req_last_i;
   logic                          valid_o;
   logic                          ready_i;
   logic [DATA_WIDTH-1:0]         data_o;
   logic                          last_o;
   logic [IDX_WIDTH-1:0]          idx_o;
   logic                          locked_o;

   modport master (
      output req_valid_i, req_data_i, req_last_i, ready_i,
      input  req_ready_o, valid_o, data_o, last_o, idx_o, locked_o
   );

   modport slave (
      input  req_valid_i, req_data_i, req_last_i, ready_i,
      output req_ready_o, valid_o, data_o, last_o, idx_o, locked_o
   );
endinterface

// File: rtl/axi_slice_rr_arbiter.sv
// Round-robin arbiter into one registered valid/ready stage; burst lock under AXI_SLICE_ARB_BURST_LOCK_EN.
// Latency 1 cycle; stage reloads when empty or draining, holds all outputs while ready_i is low.
module axi_slice_rr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 64,
   parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
   input logic                   clk_i,
   input logic                   rst_i,
   axi_slice_rr_arbiter_if.slave bus
);

   logic                  r_vld;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_last;
   logic [IDX_WIDTH-1:0]  r_idx;
   logic [IDX_WIDTH-1:0]  r_ptr;

   logic                  w_accept;
   logic                  w_load;
   logic                  w_locked;
   logic [IDX_WIDTH-1:0]  w_lidx;
   logic                  w_scan_vld;
   logic [IDX_WIDTH-1:0]  w_scan_win;
   logic                  w_win_vld;
   logic [IDX_WIDTH-1:0]  w_win;
   logic [DATA_WIDTH-1:0] w_win_data;
   logic                  w_win_last;

   function automatic logic [IDX_WIDTH-1:0] mod_idx(input int a);
      return IDX_WIDTH'(a % NUM_REQ);
   endfunction

   // Scan from the highest offset down so the lowest offset from r_ptr wins.
   always_comb begin
      w_scan_vld = 1'b0;
      w_scan_win = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (bus.req_valid_i[mod_idx(int'(r_ptr) + k)]) begin
            w_scan_vld = 1'b1;
            w_scan_win = mod_idx(int'(r_ptr) + k);
         end
      end
   end

`ifdef AXI_SLICE_ARB_BURST_LOCK_EN
   typedef enum logic {S_OPEN, S_LOCKED} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [IDX_WIDTH-1:0] r_lidx;
   logic [IDX_WIDTH-1:0] w_lidx_nxt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_OPEN;
         r_lidx  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_lidx  <= w_lidx_nxt;
      end
   end

   // Single-beat bursts pass straight through S_OPEN without locking.
   always_comb begin
      w_state_nxt = r_state;
      w_lidx_nxt  = r_lidx;
      case (r_state)
         S_OPEN: begin
            if (w_load && !w_win_last) begin
               w_state_nxt = S_LOCKED;
               w_lidx_nxt  = w_win;
            end
         end
         S_LOCKED: begin
            if (w_load && w_win_last) w_state_nxt = S_OPEN;
         end
         default: w_state_nxt = S_OPEN;
      endcase
   end

   assign w_locked = (r_state == S_LOCKED);
   assign w_lidx   = r_lidx;
`else
   assign w_locked = 1'b0;
   assign w_lidx   = '0;
`endif

   always_comb begin
      if (w_locked) begin
         w_win_vld = bus.req_valid_i[w_lidx];
         w_win     = w_lidx;
      end else begin
         w_win_vld = w_scan_vld;
         w_win     = w_scan_win;
      end
   end

   assign w_accept   = !r_vld || bus.ready_i;
   assign w_load     = w_accept && w_win_vld;
   assign w_win_data = bus.req_data_i[w_win * DATA_WIDTH +: DATA_WIDTH];
   assign w_win_last = bus.req_last_i[w_win];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_vld  <= 1'b0;
         r_data <= '0;
         r_last <= 1'b0;
         r_idx  <= '0;
         r_ptr  <= '0;
      end else begin
         if (w_load) begin
            r_vld  <= 1'b1;
            r_data <= w_win_data;
            r_last <= w_win_last;
            r_idx  <= w_win;
         end else if (bus.ready_i) begin
            r_vld <= 1'b0;
         end
`ifdef AXI_SLICE_ARB_BURST_LOCK_EN
         if (w_load && w_win_last) r_ptr <= mod_idx(int'(w_win) + 1);
`else
         if (w_load) r_ptr <= mod_idx(int'(w_win) + 1);
`endif
      end
   end

   assign bus.req_ready_o = w_load ? (NUM_REQ'(1) << w_win) : '0;
   assign bus.valid_o     = r_vld;
   assign bus.data_o      = r_data;
   assign bus.last_o      = r_last;
   assign bus.idx_o       = r_idx;
   assign bus.locked_o    = w_locked;

endmodule

// File: tb/tb_axi_slice_rr_arbiter.sv
// Bench for axi_slice_rr_arbiter: vector table, directed corner sequences, randomized run vs reference model.
module tb_axi_slice_rr_arbiter;
   localparam int N  = 4;
   localparam int DW = 16;
`ifdef AXI_SLICE_ARB_BURST_LOCK_EN
   localparam bit LOCK_ON = 1'b1;
`else
   localparam bit LOCK_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   axi_slice_rr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();
   axi_slice_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] dat [N];

   // reference model state
   bit            m_known = 1'b0;
   bit            m_vld;
   logic [DW-1:0] m_data;
   bit            m_last;
   int            m_idx;
   int            m_ptr;
   bit            m_lock;
   int            m_lidx;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit r, input logic [N-1:0] v, input logic [N-1:0] l, input bit rd);
      rst             = r;
      bus.req_valid_i = v;
      bus.req_last_i  = l;
      bus.ready_i     = rd;
      for (int i = 0; i < N; i++) bus.req_data_i[i*DW +: DW] = dat[i];
   endtask

   // Candidate order is the rotation starting at the pointer; a lock narrows it to one requester.
   function automatic int m_winner();
      int order[$];
      if (m_lock) return bus.req_valid_i[m_lidx] ? m_lidx : -1;
      for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
      foreach (order[i]) if (bus.req_valid_i[order[i]]) return order[i];
      return -1;
   endfunction

   // One clock: compare against the model mid-cycle, advance the model, return just after the edge.
   task automatic cycle();
      int            w;
      bit            acc;
      logic [N-1:0]  exp_rdy;
      @(negedge clk);
      w   = m_winner();
      acc = !m_vld || bus.ready_i;
      exp_rdy = (acc && w >= 0) ? (N'(1) << w) : '0;
      if (m_known) begin
         if (!rst) chk("mdl_req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
         chk("mdl_valid", 64'(bus.valid_o), 64'(m_vld));
         chk("mdl_data", 64'(bus.data_o), 64'(m_data));
         chk("mdl_last", 64'(bus.last_o), 64'(m_last));
         chk("mdl_idx", 64'(bus.idx_o), 64'(m_idx));
         chk("mdl_locked", 64'(bus.locked_o), 64'(m_lock));
      end
      if (rst) begin
         m_known = 1'b1;
         m_vld = 0; m_data = '0; m_last = 0; m_idx = 0; m_ptr = 0; m_lock = 0; m_lidx = 0;
      end else if (acc && w >= 0) begin
         m_vld  = 1'b1;
         m_data = dat[w];
         m_last = bus.req_last_i[w];
         m_idx  = w;
         if (!LOCK_ON || m_last) begin
            m_ptr  = (w + 1) % N;
            m_lock = 1'b0;
         end else begin
            m_lock = 1'b1;
            m_lidx = w;
         end
      end else if (bus.ready_i) begin
         m_vld = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b1, '0, '0, 1'b0);
      cycle();
   endtask

   typedef struct {
      bit           rst;
      logic [N-1:0] vld;
      logic [N-1:0] lst;
      bit           rdy;
      bit           e_vld;
      int           e_idx;
   } vec_t;

   vec_t tbl [7];

   initial begin
      int           rem [N];
      int           e_idx [4];
      bit           e_lck [4];
      logic [N-1:0] v, l, g;

      for (int i = 0; i < N; i++) dat[i] = DW'(16'h00D0 + i);

      // Fairness: all requesters valid, single-beat bursts, sink always ready.
      tbl[0] = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 0};
      tbl[1] = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 0};
      tbl[2] = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 1};
      tbl[3] = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2};
      tbl[4] = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 3};
      tbl[5] = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 0};
      tbl[6] = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 1};

      for (int i = 0; i < 7; i++) begin
         drive(tbl[i].rst, tbl[i].vld, tbl[i].lst, tbl[i].rdy);
         cycle();
         chk("tbl_valid", 64'(bus.valid_o), 64'(tbl[i].e_vld));
         chk("tbl_idx", 64'(bus.idx_o), 64'(tbl[i].e_idx));
         if (tbl[i].e_vld) chk("tbl_data", 64'(bus.data_o), 64'(dat[tbl[i].e_idx]));
      end

      // Backpressure: stage holds 0xA5 while the sink stalls.
      do_reset();
      dat[1] = DW'(16'h00A5);
      drive(1'b0, 4'b0010, 4'hF, 1'b0);
      cycle();
      chk("bp_load_data", 64'(bus.data_o), 64'h00A5);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 4'hF, 4'hF, 1'b0);
         #1;
         chk("bp_req_ready", 64'(bus.req_ready_o), 64'h0);
         cycle();
         chk("bp_data_held", 64'(bus.data_o), 64'h00A5);
         chk("bp_valid_held", 64'(bus.valid_o), 64'h1);
      end
      drive(1'b0, 4'b0100, 4'hF, 1'b1);
      #1;
      chk("bp_release_ready", 64'(bus.req_ready_o), 64'b0100);
      cycle();
      chk("bp_release_idx", 64'(bus.idx_o), 64'd2);
      chk("bp_release_data", 64'(bus.data_o), 64'(dat[2]));
      dat[1] = DW'(16'h00D1);

      // Two 2-beat bursts from req0 and req1; requesters advance on their own grants.
      if (LOCK_ON) begin
         e_idx = '{0, 0, 1, 1};
         e_lck = '{1'b1, 1'b0, 1'b1, 1'b0};
      end else begin
         e_idx = '{0, 1, 0, 1};
         e_lck = '{1'b0, 1'b0, 1'b0, 1'b0};
      end
      do_reset();
      rem = '{2, 2, 0, 0};
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < N; i++) begin
            v[i] = (rem[i] > 0);
            l[i] = (rem[i] == 1);
         end
         drive(1'b0, v, l, 1'b1);
         #1;
         g = bus.req_ready_o;
         cycle();
         chk("burst_idx", 64'(bus.idx_o), 64'(e_idx[b]));
         chk("burst_locked", 64'(bus.locked_o), 64'(e_lck[b]));
         for (int i = 0; i < N; i++) if (g[i]) rem[i]--;
      end

      // Pointer wrap after a lone grant to the top requester.
      do_reset();
      drive(1'b0, 4'b1000, 4'hF, 1'b1);
      cycle();
      chk("wrap_idx3", 64'(bus.idx_o), 64'd3);
      drive(1'b0, 4'b0101, 4'hF, 1'b1);
      cycle();
      chk("wrap_idx0", 64'(bus.idx_o), 64'd0);

      // Reset in the middle of a req2 burst.
      do_reset();
      drive(1'b0, 4'b0100, 4'b0000, 1'b1);
      cycle();
      chk("rstmid_idx", 64'(bus.idx_o), 64'd2);
      chk("rstmid_locked", 64'(bus.locked_o), 64'(LOCK_ON));
      drive(1'b1, 4'b0100, 4'b0000, 1'b1);
      cycle();
      chk("rstmid_valid", 64'(bus.valid_o), 64'd0);
      chk("rstmid_lock_clr", 64'(bus.locked_o), 64'd0);
      drive(1'b0, 4'b0110, 4'hF, 1'b1);
      cycle();
      chk("rstmid_first", 64'(bus.idx_o), 64'd1);

      // Randomized run, model compares every cycle.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) dat[i] = DW'($urandom);
         drive(($urandom_range(0, 199) == 0),
               N'($urandom),
               N'($urandom) | N'($urandom),
               ($urandom_range(0, 3) != 0));
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
